// File: rtl/si_tag_stream_decoder.sv
// si_tag_stream_decoder: converts up to NUMBER_OF_WORDS 32-bit tag words per beat into 64-bit tag times
//   clk, rst_n        : sole clock, asynchronous active-low reset
//   s_axis_*          : tag words (lane i = tdata[32i+:32], present when its 4 keep bits are set),
//                       rollover count in tuser, tlast ignored
//   m_axis_*          : per-lane tag time (1/3 ps), channel, edge, tkeep; tvalid = |tkeep
//   cfg_edge_enable   : per-edge filter, bit e gates edge index e
//   cfg_offset_wr_*   : write port of the per-edge signed tag-time offset table
//   stat_*            : saturating delivered / filtered tag counters, stat_clear zeroes both
module si_tag_stream_decoder #(
    parameter int CHANNEL_COUNT   = 20,
    parameter int DATA_WIDTH_IN   = 128,
    parameter int KEEP_WIDTH_IN   = DATA_WIDTH_IN / 8,
    parameter int NUMBER_OF_WORDS = DATA_WIDTH_IN / 32,
    parameter int COUNTER_PERIOD  = 4000,
    parameter int OFFSET_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH_IN-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH_IN-1:0]     s_axis_tkeep,
    input  logic                         s_axis_tlast,
    input  logic [31:0]                  s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [63:0]                  m_axis_tagtime [NUMBER_OF_WORDS],
    output logic [4:0]                   m_axis_channel [NUMBER_OF_WORDS],
    output logic                         m_axis_rising_edge [NUMBER_OF_WORDS],
    output logic [NUMBER_OF_WORDS-1:0]   m_axis_tkeep,
    input  logic [2*CHANNEL_COUNT-1:0]   cfg_edge_enable,
    input  logic                         cfg_offset_wr_en,
    input  logic [5:0]                   cfg_offset_wr_addr,
    input  logic [OFFSET_WIDTH-1:0]      cfg_offset_wr_data,
    input  logic                         stat_clear,
    output logic [31:0]                  stat_tag_count,
    output logic [31:0]                  stat_filtered_count
);
    localparam int EDGES = 2 * CHANNEL_COUNT;
    localparam int NW    = NUMBER_OF_WORDS;

    typedef struct packed {
        logic       pass;
        logic       filt;
        logic       rise;
        logic [4:0] chan;
    } side_t;

    logic                    ce;
    logic [31:0]             wrap1, wrap2;
    logic [OFFSET_WIDTH-1:0] offset_ram [EDGES];
    logic [NW-1:0]           filt5;
    logic                    unused_tlast;

    // The whole pipeline moves in lockstep; an empty output stage never stalls it.
    assign ce            = m_axis_tready || !m_axis_tvalid;
    assign s_axis_tready = ce;
    assign m_axis_tvalid = |m_axis_tkeep;
    assign unused_tlast  = s_axis_tlast;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [NW-1:0] v);
        logic [32:0] s;
        s = {1'b0, a} + 33'($countones(v));
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < EDGES; e++) offset_ram[e] <= '0;
        end else if (cfg_offset_wr_en && 32'(cfg_offset_wr_addr) < EDGES) begin
            offset_ram[cfg_offset_wr_addr] <= cfg_offset_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap1 <= '0;
            wrap2 <= '0;
        end else if (ce) begin
            wrap1 <= s_axis_tvalid ? s_axis_tuser : '0;
            wrap2 <= wrap1;
        end
    end

    // Every ce edge retires the output stage, whether or not it was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tag_count      <= '0;
            stat_filtered_count <= '0;
        end else if (stat_clear) begin
            stat_tag_count      <= '0;
            stat_filtered_count <= '0;
        end else if (ce) begin
            stat_tag_count      <= sat_add(stat_tag_count, m_axis_tkeep);
            stat_filtered_count <= sat_add(stat_filtered_count, filt5);
        end
    end

    for (genvar i = 0; i < NW; i++) begin : g_lane
        logic [31:0]             w1;
        logic [5:0]              ch;
        logic                    tag, in_range, low, ok;
        side_t                   sd2, sd3, sd4, sd5;
        logic [11:0]             sub2, cnt2, sub3;
        logic [OFFSET_WIDTH-1:0] off2, off3;
        logic [63:0]             prod3, time4, time5;

        assign ch       = w1[29:24];
        assign tag      = w1[31:30] == 2'b01;
        assign in_range = 32'(ch) < EDGES;
        assign low      = 32'(ch) < CHANNEL_COUNT;
        assign ok       = tag && in_range && cfg_edge_enable[ch];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                w1    <= '0;
                sd2   <= '0;
                sub2  <= '0;
                cnt2  <= '0;
                off2  <= '0;
                sd3   <= '0;
                sub3  <= '0;
                off3  <= '0;
                prod3 <= '0;
                sd4   <= '0;
                time4 <= '0;
                sd5   <= '0;
                time5 <= '0;
            end else if (ce) begin
                w1    <= (s_axis_tvalid && &s_axis_tkeep[4*i +: 4]) ? s_axis_tdata[32*i +: 32] : '0;
                sd2   <= '{pass: ok, filt: tag && !ok, rise: low,
                           chan: low ? ch[4:0] : 5'(ch - 6'(CHANNEL_COUNT))};
                sub2  <= w1[23:12];
                cnt2  <= w1[11:0];
                off2  <= in_range ? offset_ram[ch] : '0;
                sd3   <= sd2;
                sub3  <= sub2;
                off3  <= off2;
                prod3 <= 64'({wrap2, cnt2}) * 64'(COUNTER_PERIOD);
                sd4   <= sd3;
                time4 <= prod3 + 64'(sub3) + 64'($signed(off3));
                sd5   <= sd4;
                time5 <= time4;
            end
        end

        assign m_axis_tagtime[i]     = time5;
        assign m_axis_channel[i]     = sd5.chan;
        assign m_axis_rising_edge[i] = sd5.rise;
        assign m_axis_tkeep[i]       = sd5.pass;
        assign filt5[i]              = sd5.filt;
    end
endmodule

// File: tb/tb_si_tag_stream_decoder.sv
// tb_si_tag_stream_decoder: scoreboard bench for si_tag_stream_decoder
module tb_si_tag_stream_decoder;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         s_axis_tvalid = 0;
    logic         s_axis_tready;
    logic [127:0] s_axis_tdata = '0;
    logic [15:0]  s_axis_tkeep = '0;
    logic         s_axis_tlast = 0;
    logic [31:0]  s_axis_tuser = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1;
    logic [63:0]  m_axis_tagtime [4];
    logic [4:0]   m_axis_channel [4];
    logic         m_axis_rising_edge [4];
    logic [3:0]   m_axis_tkeep;
    logic [39:0]  cfg_edge_enable = '0;
    logic         cfg_offset_wr_en = 0;
    logic [5:0]   cfg_offset_wr_addr = '0;
    logic [31:0]  cfg_offset_wr_data = '0;
    logic         stat_clear = 0;
    logic [31:0]  stat_tag_count;
    logic [31:0]  stat_filtered_count;

    typedef struct packed {
        logic [3:0]       keep;
        logic [3:0][63:0] t;
        logic [3:0][4:0]  ch;
        logic [3:0]       r;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   got = 0;
    logic bp_on = 0;
    int   bp_cyc = 0;

    si_tag_stream_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tagtime(m_axis_tagtime), .m_axis_channel(m_axis_channel),
        .m_axis_rising_edge(m_axis_rising_edge), .m_axis_tkeep(m_axis_tkeep),
        .cfg_edge_enable(cfg_edge_enable), .cfg_offset_wr_en(cfg_offset_wr_en),
        .cfg_offset_wr_addr(cfg_offset_wr_addr), .cfg_offset_wr_data(cfg_offset_wr_data),
        .stat_clear(stat_clear), .stat_tag_count(stat_tag_count),
        .stat_filtered_count(stat_filtered_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called 2 time units after a rising edge; returns at the same phase after acceptance.
    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic [31:0] u);
        int n = 0;
        s_axis_tvalid = 1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        #1;
        while (!s_axis_tready && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (n == 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_axis_tready 0 for 100 cycles expected 1");
        end
        @(posedge clk);
        #2;
        s_axis_tvalid = 0;
    endtask

    // Downstream stall schedule for the backpressure stream.
    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = !(bp_on && ((bp_cyc >= 8 && bp_cyc < 11) || (bp_cyc >= 17 && bp_cyc < 20)));
        if (bp_on) bp_cyc++;
    end

    // Monitor: pops an expected beat for every handshake, checks stability while stalled.
    initial begin
        exp_t        e;
        logic [63:0] snap_t;
        logic [3:0]  snap_k;
        logic        held;
        held = 0;
        forever begin
            @(negedge clk);
            if (rst_n && m_axis_tvalid && !m_axis_tready) begin
                chk("s_axis_tready_in_stall", 64'(s_axis_tready), 64'd0);
                if (held) begin
                    chk("stall_tkeep_stable", 64'(m_axis_tkeep), 64'(snap_k));
                    chk("stall_tagtime_stable", m_axis_tagtime[0], snap_t);
                end
                held   = 1;
                snap_k = m_axis_tkeep;
                snap_t = m_axis_tagtime[0];
            end else begin
                held = 0;
                if (rst_n && m_axis_tvalid) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got tkeep %b expected no beat", m_axis_tkeep);
                    end else begin
                        e = q.pop_front();
                        got++;
                        chk("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
                        for (int l = 0; l < 4; l++) begin
                            if (e.keep[l]) begin
                                chk($sformatf("tagtime[%0d]", l), m_axis_tagtime[l], e.t[l]);
                                chk($sformatf("channel[%0d]", l), 64'(m_axis_channel[l]), 64'(e.ch[l]));
                                chk($sformatf("rising[%0d]", l), 64'(m_axis_rising_edge[l]), 64'(e.r[l]));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t         e;
        int           k;
        logic [127:0] d;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_axis_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst_tagtime0", m_axis_tagtime[0], 64'd0);
        chk("rst_channel0", 64'(m_axis_channel[0]), 64'd0);
        chk("rst_stat_tag", 64'(stat_tag_count), 64'd0);
        chk("rst_stat_filt", 64'(stat_filtered_count), 64'd0);
        rst_n = 1;
        step(2);
        chk("s_axis_tready_after_reset", 64'(s_axis_tready), 64'd1);
        cfg_edge_enable = '1;

        // Basic tag: {3,5}*4000 + 2
        e = '0; e.keep = 4'b0001; e.t[0] = 64'd49172002; e.ch[0] = 5'd1; e.r[0] = 1'b1;
        q.push_back(e);
        send({96'h0, 32'h4100_2005}, 16'hFFFF, 32'd3);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_axis_tvalid && k < 12);
        chk("latency", 64'(k), 64'd5);
        step(8);
        chk("basic_stat_tag", 64'(stat_tag_count), 64'd1);
        chk("basic_stat_filt", 64'(stat_filtered_count), 64'd0);

        // Falling edge with offset -10 on edge 21
        cfg_offset_wr_en   = 1;
        cfg_offset_wr_addr = 6'd21;
        cfg_offset_wr_data = 32'hFFFF_FFF6;
        step(1);
        cfg_offset_wr_en = 0;
        e = '0; e.keep = 4'b0100; e.t[2] = 64'd49171992; e.ch[2] = 5'd1; e.r[2] = 1'b0;
        q.push_back(e);
        send({32'h0, 32'h5500_2005, 64'h0}, 16'hFFFF, 32'd3);
        step(8);

        // Filter: disabled edge 21 in all lanes, then out-of-range edge 45
        cfg_edge_enable[21] = 1'b0;
        send({4{32'h5500_2005}}, 16'hFFFF, 32'd3);
        send({96'h0, 32'h6D00_2005}, 16'hFFFF, 32'd3);
        step(8);
        chk("filter_stat_filt", 64'(stat_filtered_count), 64'd5);
        chk("filter_stat_tag", 64'(stat_tag_count), 64'd2);
        cfg_edge_enable[21] = 1'b1;

        // Keep and non-tag words: only lane 1 (channel 2, 3*4000+1) survives
        e = '0; e.keep = 4'b0010; e.t[1] = 64'd12001; e.ch[1] = 5'd2; e.r[1] = 1'b1;
        q.push_back(e);
        send({32'h4100_2005, 32'h0, 32'h4200_1003, 32'h8100_2005}, 16'h0FFF, 32'd0);
        step(8);
        chk("keep_stat_tag", 64'(stat_tag_count), 64'd3);
        chk("keep_stat_filt", 64'(stat_filtered_count), 64'd5);

        // Backpressure stream: 20 beats, wrap 7, counter 4b+l, subtime b, channel l+4
        bp_on = 1;
        for (int b = 0; b < 20; b++) begin
            d = '0;
            e = '0;
            e.keep = 4'b1111;
            for (int l = 0; l < 4; l++) begin
                d[32*l +: 32] = {2'b01, 6'(l + 4), 12'(b), 12'(4 * b + l)};
                e.t[l]  = 64'd114688000 + 64'(4 * b + l) * 64'd4000 + 64'(b);
                e.ch[l] = 5'(l + 4);
                e.r[l]  = 1'b1;
            end
            q.push_back(e);
            send(d, 16'hFFFF, 32'd7);
        end
        step(20);
        bp_on = 0;
        chk("bp_beats_received", 64'(got), 64'd23);
        chk("bp_stat_tag", 64'(stat_tag_count), 64'd83);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Reset mid-stream: in-flight beats and the offset table are discarded
        send({32'h0, 32'h5500_2005, 64'h0}, 16'hFFFF, 32'd3);
        send({32'h0, 32'h5500_2005, 64'h0}, 16'hFFFF, 32'd3);
        rst_n = 0;
        #1;
        chk("midrst_m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_m_axis_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("midrst_tagtime2", m_axis_tagtime[2], 64'd0);
        chk("midrst_stat_tag", 64'(stat_tag_count), 64'd0);
        chk("midrst_stat_filt", 64'(stat_filtered_count), 64'd0);
        chk("midrst_s_axis_tready", 64'(s_axis_tready), 64'd1);
        step(2);
        rst_n = 1;
        step(2);
        e = '0; e.keep = 4'b0100; e.t[2] = 64'd49172002; e.ch[2] = 5'd1; e.r[2] = 1'b0;
        q.push_back(e);
        send({32'h0, 32'h5500_2005, 64'h0}, 16'hFFFF, 32'd3);
        step(8);
        chk("postrst_stat_tag", 64'(stat_tag_count), 64'd1);

        // Saturation, then clear
        force dut.stat_tag_count = 32'hFFFF_FFFE;
        #1;
        release dut.stat_tag_count;
        step(1);
        e = '0; e.keep = 4'b1111;
        for (int l = 0; l < 4; l++) begin
            e.t[l]  = 64'd49172002;
            e.ch[l] = 5'd1;
            e.r[l]  = 1'b1;
        end
        q.push_back(e);
        send({4{32'h4100_2005}}, 16'hFFFF, 32'd3);
        step(8);
        chk("sat_stat_tag", 64'(stat_tag_count), 64'hFFFF_FFFF);
        stat_clear = 1;
        step(1);
        stat_clear = 0;
        chk("clear_stat_tag", 64'(stat_tag_count), 64'd0);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/si_tag_stream_decoder.md
# si_tag_stream_decoder

Multi-word tag decoder for high-bandwidth Time Tagger links such as 40 GbE. Each cycle it converts up to NUMBER_OF_WORDS 32-bit internal tag words into absolute 64-bit tag times. Compared with the single-mode converter it adds per-edge enable filtering, a per-edge programmable signed time offset, saturating statistics counters and a fixed, documented pipeline with full AXI-Stream backpressure. It sits between the link de-framer, which supplies tag words and the rollover count in tuser, and the user measurement blocks.

## Interface
- CHANNEL_COUNT, 20: internal channel count; edge index e = channel_number, valid range 0..2*CHANNEL_COUNT-1 (max 32).
- DATA_WIDTH_IN, 128: input data width in bits; multiple of 32.
- KEEP_WIDTH_IN, DATA_WIDTH_IN/8: input keep width.
- NUMBER_OF_WORDS, DATA_WIDTH_IN/32: tag lanes per beat.
- COUNTER_PERIOD, 4000: counter tick length in 1/3 ps.
- OFFSET_WIDTH, 32: width of the signed per-edge offset.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid / s_axis_tready  in/out  1  input handshake.
- s_axis_tdata  in  DATA_WIDTH_IN  tag words; lane i = bits [32i+31:32i].
- s_axis_tkeep  in  KEEP_WIDTH_IN  lane i is present only if all 4 of its keep bits are 1.
- s_axis_tlast  in  1  ignored.
- s_axis_tuser  in  32  rollover (wrap) count for the beat.
- m_axis_tvalid / m_axis_tready  out/in  1  output handshake.
- m_axis_tagtime[NUMBER_OF_WORDS]  out  64  tag time in 1/3 ps.
- m_axis_channel[NUMBER_OF_WORDS]  out  5  0-based channel.
- m_axis_rising_edge[NUMBER_OF_WORDS]  out  1  1 = rising, 0 = falling.
- m_axis_tkeep  out  NUMBER_OF_WORDS  per-lane valid.
- cfg_edge_enable  in  2*CHANNEL_COUNT  per-edge enable; bit e gates edge index e.
- cfg_offset_wr_en  in  1  offset write strobe.
- cfg_offset_wr_addr  in  6  edge index to write.
- cfg_offset_wr_data  in  OFFSET_WIDTH  signed offset value in 1/3 ps.
- stat_clear  in  1  synchronous clear of both counters.
- stat_tag_count  out  32  tags delivered downstream, saturating.
- stat_filtered_count  out  32  tags dropped by the filter, saturating.

## Operation
- Global advance enable: ce = m_axis_tready || !m_axis_tvalid. s_axis_tready = ce. All pipeline stages advance only when ce = 1.
- Lane field decode:
  - event_type = w[31:30]
  - channel_number = w[29:24]
  - subtime = w[23:12]
  - counter = w[11:0]
  - A lane is a tag only if event_type = 2'b01. All other lane words are discarded without being counted.
- Stage S1: register the lane word. Register 0 if the beat is not valid or the lane keep is incomplete. Register tuser.
- Stage S2: decode the fields.
  - If channel_number < CHANNEL_COUNT: channel = channel_number, rising = 1.
  - Otherwise: channel = channel_number − CHANNEL_COUNT, rising = 0.
  - pass = tag && channel_number < 2*CHANNEL_COUNT && cfg_edge_enable[channel_number].
  - Read offset[channel_number] from the offset RAM.
- Stage S3: product = {wrap, counter} (44 bits) × COUNTER_PERIOD, truncated to 64 bits.
- Stage S4: tagtime = product + subtime + sign-extended offset, modulo 2^64 (wraps silently).
- Stage S5: output register.
  - m_axis_tkeep[i] = pass_i.
  - m_axis_tvalid = |m_axis_tkeep.
  - A beat with tkeep = 0 is never presented downstream.
- Offset RAM: 2*CHANNEL_COUNT × OFFSET_WIDTH, reset value 0.
  - A write to an address ≥ 2*CHANNEL_COUNT is ignored.
  - A write is visible to S2 reads on the cycle after the write strobe. A read in the same cycle as a write to the same address returns the old value.
- Statistics are updated when an S5 beat is consumed: S5 holds data and either ce = 1, or a bubble advances.
  - stat_tag_count += popcount(m_axis_tkeep).
  - stat_filtered_count += number of lanes that are tags but were rejected by the filter.
  - Both counters saturate at 0xFFFF_FFFF.
  - stat_clear takes priority over a same-cycle increment.
- cfg_edge_enable is sampled at S2. A change affects words that reach S2 from the next cycle on.

## Timing
- Latency: 5 clock edges. A beat accepted on edge N is presented on m_axis after edge N+4 and is valid during cycle N+5 when there is no stall.
- Throughput: one beat per cycle while m_axis_tready = 1.
- Backpressure:
  - While m_axis_tvalid = 1 and m_axis_tready = 0, every stage holds and s_axis_tready = 0.
  - No beat is lost or duplicated.
  - Outputs stay stable until the handshake completes.
- Bubbles (S5 empty) do not stall the pipeline: ce = 1.
- Reset (asynchronous, any time, including mid-stream):
  - All pipeline registers, m_axis_* outputs, m_axis_tvalid, both stat counters and the offset RAM go to 0.
  - s_axis_tready = 1 in the cycles after reset deasserts.
  - In-flight data is discarded.
- Simultaneous stat_clear and saturation: the counter reads 0 on the next cycle.

## Test plan
- Basic tag: lane 0 = 0x4100_2005, tuser = 3, all edges enabled, tready = 1. Expect, 5 edges later: tagtime = 49,172,002, channel = 1, rising = 1, tkeep = 4'b0001, stat_tag_count = 1.
- Falling edge and offset: write offset[21] = −10, then send lane 2 = 0x5500_2005, tuser = 3. Expect tagtime = 49,171,992, channel = 1, rising = 0, tkeep = 4'b0100.
- Filter: clear bit 21 of cfg_edge_enable and send 0x5500_2005 in all 4 lanes. Expect no m_axis_tvalid and stat_filtered_count = 4. A lane with channel_number 45 is likewise dropped and counted.
- Backpressure: stream 20 beats with a distinct counter per lane, holding m_axis_tready low for 3 cycles at beats 5 and 12. Expect s_axis_tready = 0 during the stalls, all 80 tags delivered exactly once in order, and stable outputs while stalled.
- Keep and invalid words: send tkeep = 16'h0FFF with lane 3 a valid tag, plus event_type 2'b10 in lane 0. Expect lanes 0 and 3 absent, with no increment of either counter.
- Reset and saturation:
  - Assert rst_n low mid-stream. Expect all outputs, counters and offsets at 0, no stale beat after release, and the original offset[21] = −10 no longer applied.
  - Force stat_tag_count to 0xFFFF_FFFE and deliver 4 tags. Expect it to hold at 0xFFFF_FFFF.
